// File: rtl/enc8b10b_pkg.sv
// Shared definitions for the 8b/10b datapath (encoder, serializer, future deserializer).
package enc8b10b_pkg;

  // Code-group width.
  localparam int unsigned W_SYM = 10;

  // K28.5 with RD-, abcdei fghj = 001111 1010, bit a at bit 0.
  localparam logic [W_SYM-1:0] K28_5_RDN = 10'h17C;

  // Index of the last bit of a group within the shifter.
  localparam logic [3:0] CNT_LAST = 4'd9;

  typedef enum logic {
    OFF,
    RUN
  } ser_state_e;

endpackage

// File: rtl/serializador_10b_if.sv
// Valid/ready code-group handshake between the encoder and the serializer.
interface serializador_10b_if;
  import enc8b10b_pkg::*;

  logic [W_SYM-1:0] sym_in;
  logic             sym_valid;
  logic             sym_ready;

  modport master (
    output sym_in,
    output sym_valid,
    input  sym_ready
  );

  modport slave (
    input  sym_in,
    input  sym_valid,
    output sym_ready
  );

endinterface

// File: rtl/buffer_1e.sv
// One-entry valid/ready holding register. 'pop' marks an edge where the consumer
// takes the entry; a push on the same edge refills it, so full rate has no bubbles.
module buffer_1e
  import enc8b10b_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [W_SYM-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             pop,
  output logic [W_SYM-1:0] out_data,
  output logic             full
);

  logic [W_SYM-1:0] data_q;
  logic             full_q;

  assign in_ready = ~full_q | pop;
  assign out_data = data_q;
  assign full     = full_q;

  // Capture on transfer; a pop without a refill empties the entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      data_q <= in_data;
      full_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/serializador_10b.sv
// 10-bit parallel-to-serial stage, bit a first; sends K28.5 when no group is pending.
module serializador_10b
  import enc8b10b_pkg::*;
#(
  parameter logic [W_SYM-1:0] IDLE_SYM = K28_5_RDN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enb,
  serializador_10b_if.slave   sym,
  output logic                ser_out,
  output logic                frame_start,
  output logic                comma_ins
);

  ser_state_e       state;
  logic [W_SYM-1:0] shreg;
  logic [3:0]       cnt;
  logic             comma_q;

  logic             load_now;
  logic             hold_full;
  logic [W_SYM-1:0] hold_data;

  // A new group enters the shifter on entry to RUN and after its last bit.
  assign load_now = enb & ((state == OFF) | (cnt == CNT_LAST));

  buffer_1e u_hold (
    .clk      (clk),
    .reset    (reset),
    .in_data  (sym.sym_in),
    .in_valid (sym.sym_valid),
    .in_ready (sym.sym_ready),
    .pop      (load_now),
    .out_data (hold_data),
    .full     (hold_full)
  );

  // Line FSM: load / shift in RUN, everything cleared while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= OFF;
      shreg   <= '0;
      cnt     <= '0;
      comma_q <= 1'b0;
    end else begin
      unique case (state)
        OFF: begin
          comma_q <= 1'b0;
          if (enb) begin
            state   <= RUN;
            shreg   <= hold_full ? hold_data : IDLE_SYM;
            cnt     <= '0;
            comma_q <= ~hold_full;
          end
        end
        RUN: begin
          if (!enb) begin
            // Group in flight is dropped; the hold buffer keeps its entry.
            state   <= OFF;
            shreg   <= '0;
            cnt     <= '0;
            comma_q <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            shreg   <= hold_full ? hold_data : IDLE_SYM;
            cnt     <= '0;
            comma_q <= ~hold_full;
          end else begin
            shreg   <= {1'b0, shreg[W_SYM-1:1]};
            cnt     <= cnt + 4'd1;
            comma_q <= 1'b0;
          end
        end
        default: begin
          state <= OFF;
        end
      endcase
    end
  end

  assign ser_out     = shreg[0];
  assign frame_start = (state == RUN) && (cnt == '0);
  assign comma_ins   = comma_q;

endmodule

// File: tb/tb_serializador_10b.sv
// Self-checking bench for serializador_10b: directed scenarios plus a random run,
// all checked against a bit-position reference model of the line.
module tb_serializador_10b;

  localparam logic [9:0] IDLE = 10'h17C;

  logic clk;
  logic reset;
  logic enb;
  logic ser_out;
  logic frame_start;
  logic comma_ins;

  serializador_10b_if sym_if ();

  serializador_10b dut (
    .clk         (clk),
    .reset       (reset),
    .enb         (enb),
    .sym         (sym_if),
    .ser_out     (ser_out),
    .frame_start (frame_start),
    .comma_ins   (comma_ins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: current group, bit position, pending queue (max one entry).
  bit         m_off;
  int         m_pos;
  logic [9:0] m_cur;
  logic [9:0] m_q[$];
  bit         m_comma;
  bit         m_acc;

  // Driver state.
  bit         rnd_mode;
  logic [9:0] tx_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_off   = 1'b1;
    m_pos   = 0;
    m_cur   = '0;
    m_q.delete();
    m_comma = 1'b0;
    m_acc   = 1'b0;
  endfunction

  function automatic void model_step();
    bit load;
    bit rdy;
    if (reset) begin
      m_reset();
      return;
    end
    load    = enb && (m_off || m_pos == 9);
    rdy     = (m_q.size() == 0) || load;
    m_acc   = sym_if.sym_valid && rdy;
    m_comma = 1'b0;
    if (!enb) begin
      m_off = 1'b1;
    end else if (load) begin
      if (m_q.size() != 0) begin
        m_cur = m_q.pop_front();
      end else begin
        m_cur   = IDLE;
        m_comma = 1'b1;
      end
      m_pos = 0;
      m_off = 1'b0;
    end else begin
      m_pos++;
    end
    if (m_acc) m_q.push_back(sym_if.sym_in);
  endfunction

  function automatic logic exp_ready();
    return (m_q.size() == 0) || (enb && (m_off || m_pos == 9));
  endfunction

  // One clock: check ready before the edge, advance model, check outputs, drive next inputs.
  task automatic tick();
    logic exp_ser;
    #2;
    check("sym_ready", sym_if.sym_ready, exp_ready());
    @(posedge clk);
    model_step();
    #1;
    exp_ser = m_off ? 1'b0 : m_cur[m_pos];
    check("ser_out", ser_out, exp_ser);
    check("frame_start", frame_start, !m_off && m_pos == 0);
    check("comma_ins", comma_ins, m_comma);
    if (!sym_if.sym_valid || m_acc) begin
      if (rnd_mode) begin
        sym_if.sym_valid = ($urandom_range(0, 3) != 0);
        sym_if.sym_in    = 10'($urandom);
      end else if (tx_q.size() != 0) begin
        sym_if.sym_in    = tx_q.pop_front();
        sym_if.sym_valid = 1'b1;
      end else begin
        sym_if.sym_valid = 1'b0;
      end
    end
  endtask

  task automatic pulse_reset();
    #3;
    reset = 1'b1;
    m_reset();
    #1;
    check("rst_ser_out", ser_out, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_comma_ins", comma_ins, 1'b0);
    check("rst_sym_ready", sym_if.sym_ready, 1'b1);
    tick();
    reset = 1'b0;
  endtask

  // Collect the next group from the line, starting at the next frame_start.
  task automatic grab(output logic [9:0] g, output logic c);
    int n;
    g = '0;
    tick();
    n = 0;
    while (!frame_start && n < 40) begin
      tick();
      n++;
    end
    check("grab_frame_seen", frame_start, 1'b1);
    g[0] = ser_out;
    c    = comma_ins;
    for (int i = 1; i < 10; i++) begin
      tick();
      g[i] = ser_out;
    end
  endtask

  // Collect the next group that is not an inserted comma.
  task automatic grab_data(output logic [9:0] g);
    logic c;
    c = 1'b1;
    g = '0;
    for (int i = 0; i < 5 && c; i++) grab(g, c);
    check("grab_data_seen", c, 1'b0);
  endtask

  initial begin
    logic [9:0] g;
    logic       c;
    int         n;

    rnd_mode         = 1'b0;
    reset            = 1'b1;
    enb              = 1'b0;
    sym_if.sym_in    = '0;
    sym_if.sym_valid = 1'b0;
    m_reset();

    // Reset held, then released with the line off.
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    check("off_ser_out", ser_out, 1'b0);
    check("off_sym_ready", sym_if.sym_ready, 1'b1);

    // Idle line: repeated K28.5 with a comma flag per group.
    enb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      grab(g, c);
      check("idle_group", g, IDLE);
      check("idle_comma", c, 1'b1);
    end

    // Back-to-back groups, no comma between them.
    tx_q = '{10'h2AA, 10'h155};
    grab_data(g);
    check("b2b_first", g, 10'h2AA);
    grab(g, c);
    check("b2b_second", g, 10'h155);
    check("b2b_no_comma", c, 1'b0);

    // Load and accept on the same edge keep the buffer full across three groups.
    tx_q = '{10'h3C3, 10'h0A5, 10'h111};
    grab_data(g);
    check("fr_first", g, 10'h3C3);
    grab(g, c);
    check("fr_second", g, 10'h0A5);
    check("fr_second_comma", c, 1'b0);
    grab(g, c);
    check("fr_third", g, 10'h111);
    check("fr_third_comma", c, 1'b0);

    // Drop enb at cnt=4 of 3F0 with 00F buffered.
    tx_q = '{10'h3F0, 10'h00F};
    tick();
    n = 0;
    while (!(frame_start && !comma_ins) && n < 60) begin
      tick();
      n++;
    end
    check("drop_frame_seen", frame_start && !comma_ins, 1'b1);
    repeat (4) tick();
    enb = 1'b0;
    tick();
    check("drop_ser_out", ser_out, 1'b0);
    repeat (5) tick();
    enb = 1'b1;
    grab(g, c);
    check("drop_resume_group", g, 10'h00F);
    check("drop_resume_comma", c, 1'b0);

    // Asynchronous reset mid-group, then the first group is the comma.
    repeat (3) tick();
    sym_if.sym_valid = 1'b0;
    pulse_reset();
    grab(g, c);
    check("post_reset_group", g, IDLE);
    check("post_reset_comma", c, 1'b1);

    // Random traffic with enb toggling and occasional resets.
    rnd_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) enb = ~enb;
      if ($urandom_range(0, 399) == 0) pulse_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serializador_10b.md
# serializador_10b

Parallel-to-serial stage placed directly downstream of the 8b/10b encoder. Accepts one 10-bit code group per handshake, buffers one group, and shifts it out one bit per clock, bit `a` first. When no data is pending it sends the K28.5 comma so the line never idles without symbol framing. Its serial output feeds the line driver / loopback path.

## Interface
- `W_SYM`, 10, code-group width; fixed at 10, parameterised only for the bench.
- `IDLE_SYM`, 10'h17C, group sent when the hold buffer is empty: K28.5 RD−, `abcdei fghj` = `001111 1010` with `a` at bit 0.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `enb`  in  1  serializer enable; low = line off.
- `sym_in`  in  10  code group, bit order `j h g f i e d c b a` = [9:0], same order as the encoder output.
- `sym_valid`  in  1  `sym_in` is valid this cycle.
- `sym_ready`  out  1  the block accepts `sym_in` this cycle.
- `ser_out`  out  1  serial bit.
- `frame_start`  out  1  high while `ser_out` carries bit `a` of a group.
- `comma_ins`  out  1  high for one cycle on each edge that loads `IDLE_SYM` instead of buffered data.

## Operation
- State machine with two states:
  - OFF: reset state, and the state whenever `enb`=0.
  - RUN.
- Registers:
  - `shreg[9:0]`: shift register.
  - `cnt[3:0]`: counts 0..9.
  - `hold[9:0]` plus `hold_full`: one-entry holding buffer.
- OFF → RUN on an edge with `enb`=1:
  - `shreg` loads `hold` if `hold_full`, else `IDLE_SYM`.
  - `cnt` ← 0.
  - A load from `hold` clears `hold_full`.
- In RUN with `enb`=1:
  - If `cnt`≠9: shift `shreg` right by one (0 enters at the MSB), `cnt`+1.
  - If `cnt`=9: perform the same load as on entry to RUN and set `cnt` ← 0.
- In RUN with `enb`=0: go to OFF on the next edge.
  - `shreg` ← 0 and `cnt` ← 0.
  - The group in flight is abandoned, not resent.
  - `hold` and `hold_full` are kept.
- Handshake:
  - Accept (transfer) when `sym_valid` & `sym_ready` at an edge; `hold` ← `sym_in` and `hold_full` ← 1.
  - `sym_ready` = ~`hold_full` | `load_now`, where `load_now` = a load from `hold` at this edge (RUN & `cnt`=9 & `enb`, or OFF & `enb`).
  - When a load and an accept happen at the same edge, the buffer stays full with the new group. This gives zero bubbles at full rate.
  - `sym_in` must be held stable while `sym_valid`=1 and `sym_ready`=0.
- Outputs:
  - `ser_out` = `shreg[0]`.
  - `frame_start` = RUN & `cnt`=0.
  - `comma_ins` is registered and asserts in the cycle after an `IDLE_SYM` load.
- No running-disparity tracking: groups are sent exactly as received.

## Timing
- Reset values: `ser_out`=0, `frame_start`=0, `comma_ins`=0, `sym_ready`=1, `hold_full`=0, state OFF.
- Throughput: one group per 10 clocks; `sym_ready` can be high at most once per group while the buffer is full.
- Latency, load to line: a group loaded at edge L appears on `ser_out` at L+0 (bit `a`) through L+9 (bit `j`).
- Latency, accept to line: a group accepted into an empty buffer at an edge where `cnt`=k (k<9) is loaded at the edge where `cnt`=9, i.e. 9−k edges later. There is no bypass path from `sym_in` into `shreg`.
- Reset asserted mid-group: outputs go to their reset values immediately (asynchronous); the buffered group is lost.
- `enb` falling while `hold_full`=1: the buffered group is sent first after `enb` rises again.

## Structure
- Shared package `enc8b10b_pkg`:
  - `W_SYM`.
  - `K28_5_RDN` = 10'h17C.
  - State enum {OFF, RUN}.
  - The encoder and any future deserializer/comma aligner use the same package.
- One natural sub-module: `buffer_1e`, the one-entry valid/ready holding register. The shifter and FSM stay in the top module.

## Test plan
- Reset held, then released with `enb`=0 → `ser_out`=0, `sym_ready`=1, `frame_start`=0 for 20 cycles.
- `enb`=1, `sym_valid`=0 → `ser_out` repeats 0,0,1,1,1,1,1,0,1,0; `frame_start` every 10th cycle; `comma_ins` once per group.
- Send 10'h2AA then 10'h155 back-to-back with `sym_valid` held → serial stream 0101010101 then 1010101010 with no comma between them; `sym_ready` low while the buffer holds the second group.
- Load and accept at the same edge (`cnt`=9, `hold_full`=1, `sym_valid`=1) → loaded group goes to the line, new group goes into `hold`, `hold_full` stays 1, no comma inserted.
- Drop `enb` at `cnt`=4 of group 10'h3F0 with 10'h00F buffered → `ser_out`=0 next cycle; after `enb` rises, the line sends 10'h00F (1111000000), not the rest of 10'h3F0.
- Assert `reset` mid-group asynchronously → `ser_out` goes to 0 before the next edge; after release the first group sent is `IDLE_SYM`.
